// File: rtl/z80_dma_controller.sv
// Z80-style memory-to-memory DMA controller.
// The CPU programs source, destination and byte count through a small register
// file, then starts a transfer. The block requests the bus, moves bytes at two
// cycles per byte, and gives the bus back after BURST_LEN bytes so the CPU can
// run between tenures.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | no transfer; waiting for a start command
//   S_REQ     | bus requested (o_busrq_n low); waiting for bus acknowledge
//   S_RD      | one-cycle memory read at SRC; data latched at end of cycle
//   S_WR      | one-cycle memory write at DST; pointers and count advance
//   S_RELEASE | bus request dropped; waiting for the CPU to take the bus back
module z80_dma_controller #(
    parameter int BURST_LEN = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic [3:0]  i_addr,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_busrq_n,
    input  logic        i_busack_n,
    output logic [21:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    input  logic [7:0]  i_mem_data,
    output logic [7:0]  o_mem_data,
    output logic        o_bus_own,
    output logic        o_int
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_RELEASE
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

    state_t      state;
    logic [21:0] src;
    logic [21:0] dst;
    logic [15:0] count;
    logic [7:0]  burst;
    logic        int_en;
    logic        done;
    logic        busy;
    logic        final_rel;   // RELEASE ends the transfer rather than yielding

    logic reg_wr;
    logic ctrl_wr;
    logic ctrl_start;
    logic ctrl_clear;
    logic ctrl_abort;

    assign reg_wr     = i_cs & i_wr;
    assign ctrl_wr    = reg_wr && (i_addr == 4'd8);
    assign ctrl_start = ctrl_wr & i_data[0];
    assign ctrl_clear = ctrl_wr & i_data[2];
    assign ctrl_abort = ctrl_wr & i_data[3];

    assign o_int = done & int_en;

    // Register file and transfer sequencer; all outputs registered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            src        <= '0;
            dst        <= '0;
            count      <= '0;
            burst      <= '0;
            int_en     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            final_rel  <= 1'b0;
            o_busrq_n  <= 1'b1;
            o_mem_addr <= '0;
            o_mem_rd   <= 1'b0;
            o_mem_wr   <= 1'b0;
            o_mem_data <= '0;
            o_bus_own  <= 1'b0;
        end else begin
            // Clear first so a completion in the same cycle leaves done set.
            if (ctrl_wr) begin
                int_en <= i_data[1];
                if (ctrl_clear)
                    done <= 1'b0;
            end

            if (reg_wr && !busy) begin
                case (i_addr)
                    4'd0: src[7:0]   <= i_data;
                    4'd1: src[15:8]  <= i_data;
                    4'd2: src[21:16] <= i_data[5:0];
                    4'd3: dst[7:0]   <= i_data;
                    4'd4: dst[15:8]  <= i_data;
                    4'd5: dst[21:16] <= i_data[5:0];
                    4'd6: count[7:0] <= i_data;
                    4'd7: count[15:8] <= i_data;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        if (count != 16'd0) begin
                            state     <= S_REQ;
                            busy      <= 1'b1;
                            o_busrq_n <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (ctrl_abort) begin
                        state     <= S_RELEASE;
                        final_rel <= 1'b1;
                        o_busrq_n <= 1'b1;
                    end else if (!i_busack_n) begin
                        state      <= S_RD;
                        burst      <= '0;
                        o_bus_own  <= 1'b1;
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= src;
                    end
                end

                S_RD: begin
                    o_mem_rd <= 1'b0;
                    if (ctrl_abort) begin
                        // The read byte is dropped; pointers stay at this byte.
                        state     <= S_RELEASE;
                        final_rel <= 1'b1;
                        o_busrq_n <= 1'b1;
                        o_bus_own <= 1'b0;
                    end else begin
                        state      <= S_WR;
                        o_mem_data <= i_mem_data;
                        o_mem_wr   <= 1'b1;
                        o_mem_addr <= dst;
                    end
                end

                S_WR: begin
                    o_mem_wr <= 1'b0;
                    src      <= src + 22'd1;
                    dst      <= dst + 22'd1;
                    count    <= count - 16'd1;
                    burst    <= burst + 8'd1;
                    if (count == 16'd1 || ctrl_abort) begin
                        state     <= S_RELEASE;
                        final_rel <= 1'b1;
                        o_busrq_n <= 1'b1;
                        o_bus_own <= 1'b0;
                    end else if (burst == BURST_LAST) begin
                        state     <= S_RELEASE;
                        final_rel <= 1'b0;
                        o_busrq_n <= 1'b1;
                        o_bus_own <= 1'b0;
                    end else begin
                        state      <= S_RD;
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= src + 22'd1;
                    end
                end

                S_RELEASE: begin
                    if (ctrl_abort)
                        final_rel <= 1'b1;
                    if (i_busack_n) begin
                        if (final_rel || ctrl_abort) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_REQ;
                            o_busrq_n <= 1'b0;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Register read mux; zero unless the CPU is reading this block.
    always_comb begin
        o_data = 8'h00;
        if (i_cs && i_rd) begin
            case (i_addr)
                4'd0: o_data = src[7:0];
                4'd1: o_data = src[15:8];
                4'd2: o_data = {2'b00, src[21:16]};
                4'd3: o_data = dst[7:0];
                4'd4: o_data = dst[15:8];
                4'd5: o_data = {2'b00, dst[21:16]};
                4'd6: o_data = count[7:0];
                4'd7: o_data = count[15:8];
                4'd8: o_data = {5'b00000, int_en, done, busy};
                default: o_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_dma_controller.sv
// Bench for z80_dma_controller: directed transfers with a bus arbiter model,
// a pattern memory, and a scoreboard monitor on the memory strobes.
module tb_z80_dma_controller;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busrq_n;
    logic        busack_n;
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        bus_own;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_rd_q[$];
    logic [29:0] exp_wr_q[$];
    int          tenure_q[$];
    int          cyc = 0;
    int          first_rd_cyc = -1;
    int          last_wr_cyc = -1;
    int          wr_count = 0;
    bit          busrq_seen = 0;

    z80_dma_controller #(.BURST_LEN(16)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_cs       (cs),
        .i_addr     (addr),
        .i_rd       (rd),
        .i_wr       (wr),
        .i_data     (wdata),
        .o_data     (rdata),
        .o_busrq_n  (busrq_n),
        .i_busack_n (busack_n),
        .o_mem_addr (mem_addr),
        .o_mem_rd   (mem_rd),
        .o_mem_wr   (mem_wr),
        .i_mem_data (mem_rdata),
        .o_mem_data (mem_wdata),
        .o_bus_own  (bus_own),
        .o_int      (irq)
    );

    function automatic logic [7:0] pat(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA5;
    endfunction

    assign mem_rdata = pat(mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus arbiter: grant 3 cycles after request, take the bus back 2 cycles after release.
    initial begin
        int gcnt = 0;
        int rcnt = 0;
        busack_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!busrq_n && busack_n) begin
                gcnt++;
                if (gcnt >= 3) begin busack_n = 1'b0; gcnt = 0; end
            end else if (busrq_n && !busack_n) begin
                rcnt++;
                if (rcnt >= 2) begin busack_n = 1'b1; rcnt = 0; end
            end else begin
                gcnt = 0;
                rcnt = 0;
            end
        end
    end

    // Monitor: pops expected reads/writes on each strobe and tracks tenures.
    initial begin
        bit in_tenure = 0;
        int ten_len = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (!busrq_n) begin
                    busrq_seen = 1;
                    in_tenure = 1;
                end else if (in_tenure) begin
                    tenure_q.push_back(ten_len);
                    in_tenure = 0;
                    ten_len = 0;
                end
                if (mem_rd || mem_wr) begin
                    check("strobe_excl", {30'd0, mem_rd, mem_wr} == 32'd3, 1'b0);
                    check("strobe_own", {31'd0, bus_own}, 32'd1);
                end
                if (mem_rd) begin
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    if (exp_rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_unexpected actual=%h required=none", mem_addr);
                    end else begin
                        check("rd_addr", {10'd0, mem_addr}, {10'd0, exp_rd_q.pop_front()});
                    end
                end
                if (mem_wr) begin
                    last_wr_cyc = cyc;
                    wr_count++;
                    ten_len++;
                    if (exp_wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_unexpected actual=%h required=none", {mem_addr, mem_wdata});
                    end else begin
                        check("wr_addr_data", {2'd0, mem_addr, mem_wdata}, {2'd0, exp_wr_q.pop_front()});
                    end
                end
            end else begin
                in_tenure = 0;
                ten_len = 0;
            end
        end
    end

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = rdata;
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        reg_read(a, d);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic setup(input logic [21:0] s, input logic [21:0] d, input logic [15:0] n);
        reg_write(4'd0, s[7:0]);
        reg_write(4'd1, s[15:8]);
        reg_write(4'd2, {2'b00, s[21:16]});
        reg_write(4'd3, d[7:0]);
        reg_write(4'd4, d[15:8]);
        reg_write(4'd5, {2'b00, d[21:16]});
        reg_write(4'd6, n[7:0]);
        reg_write(4'd7, n[15:8]);
    endtask

    task automatic plan(input logic [21:0] s, input logic [21:0] d, input int nrd, input int nwr);
        logic [21:0] sa;
        logic [21:0] da;
        for (int i = 0; i < nrd; i++) begin
            sa = s + 22'(i);
            exp_rd_q.push_back(sa);
        end
        for (int i = 0; i < nwr; i++) begin
            sa = s + 22'(i);
            da = d + 22'(i);
            exp_wr_q.push_back({da, pat(sa)});
        end
    endtask

    task automatic wait_idle(input string name);
        logic [7:0] st;
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            reg_read(4'd8, st);
            if (!st[0]) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic check_queues(input string name);
        check({name, "_rd_left"}, exp_rd_q.size(), 0);
        check({name, "_wr_left"}, exp_wr_q.size(), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        bit ok;
        cs = 0; rd = 0; wr = 0; addr = 4'd0; wdata = 8'h00;
        rst = 1'b1;

        // Reset state, with a STATUS read held active.
        repeat (3) @(negedge clk);
        cs = 1; rd = 1; addr = 4'd8;
        #1;
        check("rst_busrq_n", {31'd0, busrq_n}, 32'd1);
        check("rst_strobes", {29'd0, mem_rd, mem_wr, bus_own}, 32'd0);
        check("rst_int", {31'd0, irq}, 32'd0);
        check("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
        check("rst_mem_data", {24'd0, mem_wdata}, 32'd0);
        check("rst_o_data", {24'd0, rdata}, 32'd0);
        cs = 0; rd = 0;
        @(negedge clk);
        rst = 1'b0;
        check_reg("rst_count_lo", 4'd6, 8'h00);
        check_reg("rst_status", 4'd8, 8'h00);

        // Unused register: write ignored, reads 0.
        reg_write(4'd9, 8'h5A);
        check_reg("reg9_zero", 4'd9, 8'h00);

        // Basic 4-byte transfer.
        tenure_q.delete();
        setup(22'h000100, 22'h200000, 16'd4);
        check_reg("src_readback", 4'd0, 8'h00);
        check_reg("dst_readback", 4'd5, 8'h20);
        plan(22'h000100, 22'h200000, 4, 4);
        first_rd_cyc = -1;
        reg_write(4'd8, 8'h01);
        wait_idle("basic");
        check_queues("basic");
        check("basic_cycles", last_wr_cyc - first_rd_cyc + 1, 8);
        check_reg("basic_count", 4'd6, 8'h00);
        check_reg("basic_src", 4'd0, 8'h04);
        check_reg("basic_dst", 4'd3, 8'h04);
        check_reg("basic_status", 4'd8, 8'h02);
        check("basic_tenures", tenure_q.size(), 1);

        // 40 bytes -> tenures of 16, 16, 8; writes while busy are ignored.
        reg_write(4'd8, 8'h04);
        tenure_q.delete();
        setup(22'h001000, 22'h010000, 16'd40);
        plan(22'h001000, 22'h010000, 40, 40);
        reg_write(4'd8, 8'h01);
        reg_write(4'd6, 8'h55);
        reg_write(4'd0, 8'hAA);
        wait_idle("burst");
        check_queues("burst");
        check("burst_tenures", tenure_q.size(), 3);
        if (tenure_q.size() == 3) begin
            check("burst_t0", tenure_q[0], 16);
            check("burst_t1", tenure_q[1], 16);
            check("burst_t2", tenure_q[2], 8);
        end
        check_reg("burst_count", 4'd6, 8'h00);
        check_reg("burst_src", 4'd0, 8'h28);

        // Source wraps at 2^22.
        reg_write(4'd8, 8'h04);
        setup(22'h3FFFFE, 22'h000200, 16'd3);
        plan(22'h3FFFFE, 22'h000200, 3, 3);
        reg_write(4'd8, 8'h01);
        wait_idle("wrap");
        check_queues("wrap");
        check_reg("wrap_src_lo", 4'd0, 8'h01);
        check_reg("wrap_src_hi", 4'd2, 8'h00);

        // COUNT == 0: done at once, no bus request.
        reg_write(4'd8, 8'h04);
        check_reg("clear_status", 4'd8, 8'h00);
        reg_write(4'd6, 8'h00);
        reg_write(4'd7, 8'h00);
        busrq_seen = 0;
        tenure_q.delete();
        reg_write(4'd8, 8'h01);
        check_reg("zero_status", 4'd8, 8'h02);
        repeat (8) @(negedge clk);
        check("zero_no_busrq", {31'd0, busrq_seen}, 32'd0);
        check("zero_no_tenure", tenure_q.size(), 0);

        // Interrupt on completion, cleared by clear-done.
        reg_write(4'd8, 8'h06);
        setup(22'h000300, 22'h000400, 16'd2);
        plan(22'h000300, 22'h000400, 2, 2);
        reg_write(4'd8, 8'h03);
        wait_idle("irq");
        check_queues("irq");
        #1;
        check("irq_set", {31'd0, irq}, 32'd1);
        reg_write(4'd8, 8'h06);
        check("irq_clear", {31'd0, irq}, 32'd0);

        // Abort after two bytes of ten: third read seen, then bus released.
        reg_write(4'd8, 8'h04);
        tenure_q.delete();
        setup(22'h002000, 22'h003000, 16'd10);
        plan(22'h002000, 22'h003000, 3, 2);
        wr_count = 0;
        reg_write(4'd8, 8'h01);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (wr_count >= 2) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL abort_wait actual=%0d required=2", wr_count);
        end
        reg_write(4'd8, 8'h08);
        wait_idle("abort");
        check_queues("abort");
        check_reg("abort_count_lo", 4'd6, 8'h08);
        check_reg("abort_count_hi", 4'd7, 8'h00);
        check_reg("abort_status", 4'd8, 8'h02);
        check("abort_busrq_n", {31'd0, busrq_n}, 32'd1);
        check("abort_tenure", (tenure_q.size() == 1) ? tenure_q[0] : -1, 2);

        // Reset in the middle of a read.
        reg_write(4'd8, 8'h04);
        setup(22'h004000, 22'h005000, 16'd5);
        reg_write(4'd8, 8'h03);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (mem_rd) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rstmid_wait actual=0 required=rd");
        end
        rst = 1'b1;
        cs = 1; rd = 1; addr = 4'd6;
        #1;
        check("rstmid_busrq_n", {31'd0, busrq_n}, 32'd1);
        check("rstmid_strobes", {29'd0, mem_rd, mem_wr, bus_own}, 32'd0);
        check("rstmid_addr_data", {2'd0, mem_addr, mem_wdata}, 32'd0);
        check("rstmid_int_odata", {23'd0, irq, rdata}, 32'd0);
        cs = 0; rd = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reg("rstmid_status", 4'd8, 8'h00);
        check_reg("rstmid_count", 4'd6, 8'h00);
        check_reg("rstmid_src", 4'd1, 8'h00);
        repeat (6) @(negedge clk);
        check_queues("rstmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_dma_controller.md
Z80_DMA_CONTROLLER -- requirements
Module: z80_dma_controller

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning the maximum number of bytes moved per bus tenure before the bus is released (range 1-255).
REQ-002 SHALL have port i_clk  input  1  system clock (the CPU clock); all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_cs  input  1  register select from the I/O decode.
REQ-005 SHALL have port i_addr  input  4  register index.
REQ-006 SHALL have ports i_rd / i_wr  input  1 each  register read / write strobes, qualified by i_cs.
REQ-007 SHALL have ports i_data  input  8  register write data; o_data  output  8  register read data.
REQ-008 SHALL have ports o_busrq_n  output  1  CPU bus request; i_busack_n  input  1  CPU bus acknowledge.
REQ-009 SHALL have ports o_mem_addr  output  22  memory address; o_mem_rd / o_mem_wr  output  1 each  memory strobes.
REQ-010 SHALL have ports i_mem_data  input  8  memory read data (combinational source); o_mem_data  output  8  memory write data.
REQ-011 SHALL have ports o_bus_own  output  1  high while the block drives the memory bus; o_int  output  1  interrupt, level, active-high.

Function
REQ-012 SHALL map registers: 0-2 SRC[7:0],[15:8],[21:16]; 3-5 DST likewise; 6-7 COUNT[7:0],[15:8]; 8 CTRL (write) / STATUS (read); 9-15 read 0, writes ignored.
REQ-013 SHALL decode CTRL writes: bit0 start, bit1 int_en (stored), bit2 clear done, bit3 abort.
REQ-014 SHALL return STATUS {5'b0, int_en, done, busy}; SRC/DST/COUNT reads return current (live) values; o_data SHALL be 0 when not (i_cs & i_rd).
REQ-015 SHALL ignore SRC/DST/COUNT writes and start while busy.
REQ-016 SHALL implement states IDLE, REQ, RD, WR, RELEASE.
REQ-017 IDLE: start with COUNT!=0 -> REQ, busy=1; start with COUNT==0 -> set done, stay IDLE, never assert o_busrq_n.
REQ-018 REQ: o_busrq_n=0; on i_busack_n sampled 0 -> RD, burst counter cleared.
REQ-019 RD: o_bus_own=1, o_mem_rd=1 for exactly one cycle, o_mem_addr=SRC; i_mem_data captured into the data latch at the end of the cycle -> WR.
REQ-020 WR: o_mem_wr=1 for exactly one cycle, o_mem_addr=DST, o_mem_data=latch; at end SRC+=1, DST+=1, COUNT-=1, burst+=1.
REQ-021 After WR: COUNT reaches 0 -> RELEASE (final); burst==BURST_LEN -> RELEASE (yield); else -> RD.
REQ-022 RELEASE: o_busrq_n=1, o_bus_own=0; wait for i_busack_n sampled 1; final -> IDLE, busy=0, done=1; yield -> REQ on the next cycle.
REQ-023 SRC and DST SHALL wrap modulo 2^22 (3FFFFF -> 000000) with no flag.
REQ-024 Throughput SHALL be 2 cycles per byte within a tenure.
REQ-025 Abort in REQ/RD/WR SHALL go to RELEASE (final); a WR in progress completes first; registers keep their partial values; done=1.
REQ-026 Completion and clear-done in the same cycle: done SHALL end at 1.
REQ-027 o_int SHALL equal done & int_en.
REQ-028 o_mem_rd, o_mem_wr and o_bus_own SHALL never be high outside RD/WR; o_mem_rd and o_mem_wr SHALL never both be high.

Reset
REQ-029 While i_reset is high: state IDLE, SRC=DST=0, COUNT=0, int_en=0, done=0, busy=0, o_busrq_n=1, o_mem_rd=o_mem_wr=o_bus_own=0, o_int=0, o_mem_addr=0, o_mem_data=0, o_data=0.
REQ-030 Reset asserted mid-transfer SHALL immediately release the bus (o_busrq_n=1) and discard the transfer.

Verification
REQ-031 SRC=000100, DST=200000, COUNT=4, start; grant after 3 cycles -> 4 RD/WR pairs, 8 cycles, DST 200000-200003 equal source; done=1; COUNT=0.
REQ-032 BURST_LEN=16, COUNT=40 -> three tenures of 16, 16, 8 bytes; o_busrq_n high between them until i_busack_n returns 1.
REQ-033 SRC=3FFFFE, COUNT=3 -> reads at 3FFFFE, 3FFFFF, 000000.
REQ-034 COUNT=0, start -> done=1 next cycle; o_busrq_n stays 1.
REQ-035 int_en=1, transfer completes -> o_int=1; CTRL write of clear-done -> o_int=0 next cycle.
REQ-036 Abort after 2 bytes of 10 -> COUNT=8, bus released, done=1; reset during RD -> all outputs at reset values.
